alu_arbiter: RTL
================

# alu_arbiter

Two-requester arbiter and sequencer for the shared 8-bit ALU. It accepts operation requests (ctrl, x, y) on two valid/ready ports and grants one at a time. It drives the ALU from registered operands, captures the result, and returns it on a single valid/ready response port tagged with the requester ID. It sits between the two command sources and the combinational ALU instance, which is external to this block.

## Interface
- `ARB_W`, default 1: requester ID width (2 requesters).
- `clk` input, 1: clock, all state on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `req_valid` input, 2: per-requester command valid.
- `req_ready` output, 2: per-requester accept; at most one bit high.
- `req_ctrl` input, 2x4: per-requester ALU opcode.
- `req_x` input, 2x8: per-requester operand x.
- `req_y` input, 2x8: per-requester operand y.
- `alu_ctrl` output, 4: opcode to the ALU.
- `alu_x` output, 8: operand x to the ALU.
- `alu_y` output, 8: operand y to the ALU.
- `alu_out` input, 8: ALU result.
- `alu_carry` input, 1: ALU carry.
- `rsp_valid` output, 1: response valid.
- `rsp_ready` input, 1: response accept.
- `rsp_id` output, ARB_W: requester that issued the operation.
- `rsp_out` output, 8: result.
- `rsp_carry` output, 1: carry.
- `rsp_err` output, 1: opcode was outside 4'h0..4'hC.

## Operation
- FSM states and transitions:
  - IDLE -> EXEC on accept.
  - EXEC -> RESP unconditionally.
  - RESP -> IDLE on `rsp_valid && rsp_ready`.
- Requester rules: a requester holds `req_valid` and its payload stable until it sees `req_ready`.
- `req_ready[i]` is combinational. It is 1 only in IDLE, when `req_valid[i]` is set and `grant == i`.
- On accept, the block latches ctrl, x, y and the ID into operand registers.
- `alu_ctrl`, `alu_x` and `alu_y` are driven straight from the operand registers in every state, with no combinational path from `req_*`.
- Result capture in EXEC:
  - `rsp_out <= alu_out`, `rsp_carry <= alu_carry`.
  - If the opcode is greater than 4'hC, `rsp_err <= 1`, and `rsp_out` and `rsp_carry` are forced to 0.
- Carry is passed through unmodified. It is meaningful only for ADD (4'h0) and SUB (4'h1).
- Response outputs hold stable while `rsp_valid && !rsp_ready`.
- While not in IDLE, both `req_ready` bits are 0, including during response backpressure.
- Grant policy is selected by the macro in Configuration.
  - Only one requester valid: that requester wins under either policy.

## Timing
- Reset values (asynchronous, immediate):
  - State = IDLE.
  - `req_ready` = 0, `rsp_valid` = 0.
  - `rsp_id` = 0, `rsp_out` = 0, `rsp_carry` = 0, `rsp_err` = 0.
  - `alu_ctrl` = 0, `alu_x` = 0, `alu_y` = 0.
  - `last_grant` = 1.
- Latency:
  - An accept at edge N puts the operands on `alu_*` after N.
  - The result is captured at N+1.
  - `rsp_valid` is high after N+1 and stays high until the response handshake.
- Throughput: at best one operation per 3 cycles (IDLE, EXEC, RESP). The next accept is no earlier than the cycle after the response handshake.
- Reset mid-operation: an in-flight command is dropped with no response. `rsp_valid` falls immediately.
- If `req_valid` deasserts in IDLE before being granted, nothing is latched and the arbitration state is unchanged.

## Configuration
- Macro: `ALU_ARB_RR_EN`.
- Defined: round-robin arbitration.
  - With both requesters valid, grant goes to the one that is not `last_grant`.
  - `last_grant` updates on every accept.
  - After reset, requester 0 wins the first tie.
- Undefined: fixed priority, requester 0 always wins ties. `last_grant` and the arbitration sub-module logic are removed.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants: ADD 4'h0, SUB 4'h1, AND 4'h2, OR 4'h3, NOT 4'h4, XOR 4'h5, NOR 4'h6, SLL 4'h7, SRL 4'h8, SRA 4'h9, RL 4'hA, RR 4'hB, EQ 4'hC.
  - `OP_LAST` = 4'hC.
  - `DATA_W` = 8.
  - FSM state enum: IDLE, EXEC, RESP.
- Sub-module `alu_rr_arb`: the 2-way grant logic.
  - Inputs: `req_valid`, `last_grant`.
  - Output: one-hot grant.
  - Policy (round-robin or fixed priority) is selected by `ALU_ARB_RR_EN`.
- Top level: FSM, operand registers, result registers.

## Test plan
- Basic ADD with response handshake: after reset, req0 sends ADD x=8'hF0 y=8'h20, `rsp_ready` = 1.
  - Expect `req_ready[0]` in the accept cycle.
  - Expect `rsp_valid` 2 edges later with `rsp_id` = 0, `rsp_out` = 8'h10, `rsp_carry` = 1, `rsp_err` = 0.
- Simultaneous requests: both requesters hold valid, req0 sends SUB 8'h05-8'h03 and req1 sends XOR 8'hAA^8'hFF.
  - With `ALU_ARB_RR_EN`: responses in order id 0 (8'h02), then id 1 (8'h55).
  - Without the macro: id 0 twice while req0 stays valid.
- Response backpressure: hold `rsp_ready` = 0 for 5 cycles during RESP.
  - Expect `rsp_*` stable and both `req_ready` bits 0 throughout.
  - Expect IDLE the cycle after the handshake.
- Illegal opcode: req1 sends ctrl 4'hE.
  - Expect `rsp_err` = 1, `rsp_out` = 8'h00, `rsp_carry` = 0, `rsp_id` = 1.
- Reset mid-operation: assert `rst_n` = 0 while in EXEC.
  - Expect `rsp_valid` = 0 and `alu_*` = 0 immediately.
  - After release, with both requesters valid, req0 is granted first.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: opcodes, data width, FSM states.
package alu_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_NOT = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_NOR = 4'h6;
  localparam logic [3:0] OP_SLL = 4'h7;
  localparam logic [3:0] OP_SRL = 4'h8;
  localparam logic [3:0] OP_SRA = 4'h9;
  localparam logic [3:0] OP_RL  = 4'hA;
  localparam logic [3:0] OP_RR  = 4'hB;
  localparam logic [3:0] OP_EQ  = 4'hC;

  localparam logic [3:0] OP_LAST = OP_EQ;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of request, ALU and response signals around alu_arbiter.
// slave: the arbiter side; master: requesters, ALU and response consumer.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int ARB_W = 1
);
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0][3:0]        req_ctrl;
  logic [1:0][DATA_W-1:0] req_x;
  logic [1:0][DATA_W-1:0] req_y;

  logic [3:0]             alu_ctrl;
  logic [DATA_W-1:0]      alu_x;
  logic [DATA_W-1:0]      alu_y;
  logic [DATA_W-1:0]      alu_out;
  logic                   alu_carry;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ARB_W-1:0]       rsp_id;
  logic [DATA_W-1:0]      rsp_out;
  logic                   rsp_carry;
  logic                   rsp_err;

  modport slave (
    input  req_valid, req_ctrl, req_x, req_y, alu_out, alu_carry, rsp_ready,
    output req_ready, alu_ctrl, alu_x, alu_y, rsp_valid, rsp_id, rsp_out,
           rsp_carry, rsp_err
  );

  modport master (
    output req_valid, req_ctrl, req_x, req_y, alu_out, alu_carry, rsp_ready,
    input  req_ready, alu_ctrl, alu_x, alu_y, rsp_valid, rsp_id, rsp_out,
           rsp_carry, rsp_err
  );
endinterface

// File: rtl/alu_rr_arb.sv
// Two-way grant logic. ALU_ARB_RR_EN selects round-robin on ties;
// otherwise requester 0 has fixed priority and last_grant is not a port.
module alu_rr_arb (
  input  logic [1:0] req_valid,
`ifdef ALU_ARB_RR_EN
  input  logic       last_grant,
`endif
  output logic [1:0] grant
);

  // One-hot grant; a lone requester always wins, ties resolved by policy.
  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) begin
`ifdef ALU_ARB_RR_EN
      grant = last_grant ? 2'b01 : 2'b10;
`else
      grant = 2'b01;
`endif
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbiter/sequencer for the shared external ALU: accepts one command at a time
// from two requesters, drives the ALU from registered operands and returns a
// tagged result. Macro ALU_ARB_RR_EN enables round-robin arbitration.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int ARB_W = 1
) (
  input logic           clk,
  input logic           rst_n,
  alu_arbiter_if.slave  bus
);

  state_e            state_q, state_d;
  logic [1:0]        grant;
  logic [1:0]        ready;
  logic              accept;
  logic              sel;

  logic [3:0]        op_ctrl_q;
  logic [DATA_W-1:0] op_x_q;
  logic [DATA_W-1:0] op_y_q;
  logic [ARB_W-1:0]  op_id_q;

  logic [DATA_W-1:0] rsp_out_q;
  logic              rsp_carry_q;
  logic              rsp_err_q;

`ifdef ALU_ARB_RR_EN
  logic              last_grant_q;

  alu_rr_arb u_arb (
    .req_valid  (bus.req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );
`else
  alu_rr_arb u_arb (
    .req_valid  (bus.req_valid),
    .grant      (grant)
  );
`endif

  assign sel = grant[1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and combinational accept; ready is held low while in reset.
  always_comb begin
    state_d = state_q;
    ready   = '0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rst_n) ready = grant & bus.req_valid;
        accept = |ready;
        if (accept) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch on accept and result capture in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_ctrl_q   <= '0;
      op_x_q      <= '0;
      op_y_q      <= '0;
      op_id_q     <= '0;
      rsp_out_q   <= '0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_ctrl_q <= bus.req_ctrl[sel];
        op_x_q    <= bus.req_x[sel];
        op_y_q    <= bus.req_y[sel];
        op_id_q   <= ARB_W'(sel);
      end
      if (state_q == EXEC) begin
        if (op_ctrl_q > OP_LAST) begin
          rsp_out_q   <= '0;
          rsp_carry_q <= 1'b0;
          rsp_err_q   <= 1'b1;
        end else begin
          rsp_out_q   <= bus.alu_out;
          rsp_carry_q <= bus.alu_carry;
          rsp_err_q   <= 1'b0;
        end
      end
    end
  end

`ifdef ALU_ARB_RR_EN
  // Remember the most recent winner for tie-breaking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant_q <= 1'b1;
    else if (accept) last_grant_q <= sel;
  end
`endif

  assign bus.req_ready = ready;
  assign bus.alu_ctrl  = op_ctrl_q;
  assign bus.alu_x     = op_x_q;
  assign bus.alu_y     = op_y_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = op_id_q;
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
